tone_synth: RTL



---
 rtl/tone_synth.sv | 120 ++++++++++++
 1 files changed

// File: rtl/tone_synth.sv
// Phase-accumulator tone generator: waveform shaping, gated linear envelope
// and single-pin PWM output. Step changes are deferred to a phase wrap.
module tone_synth #(
    parameter int unsigned env_div_p = 256
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] fstep_i,
    input  logic        fstep_valid_i,
    output logic        fstep_ready_o,
    input  logic [1:0]  wave_sel_i,
    input  logic        gate_i,
    output logic [7:0]  sample_o,
    output logic        pwm_o,
    output logic        wrap_o
);
    localparam int unsigned      DIV_W    = (env_div_p > 1) ? $clog2(env_div_p) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(env_div_p - 1);

    typedef enum logic [1:0] {
        WAVE_SQUARE = 2'd0,
        WAVE_SAW    = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_OFF    = 2'd3
    } wave_e;

    logic [31:0]      r_phase;
    logic [31:0]      r_active;
    logic [31:0]      r_pending;
    logic             r_pend_v;
    logic [7:0]       r_env;
    logic [DIV_W-1:0] r_div;
    logic [7:0]       r_pwm_cnt;
    logic [7:0]       r_sample;
    logic             r_pwm;
    logic             r_wrap;

    logic [32:0]      w_sum;
    logic             w_carry;
    logic             w_accept;
    logic             w_apply;
    logic             w_tick;
    logic [7:0]       w_p;
    logic [7:0]       w_wave;
    logic [7:0]       w_scaled;

    assign w_sum    = {1'b0, r_phase} + {1'b0, r_active};
    assign w_carry  = w_sum[32];
    assign w_accept = fstep_valid_i & ~r_pend_v;
    // An idle accumulator takes the new step straight away; a running one
    // waits for its carry so the waveform never jumps mid-period.
    assign w_apply  = r_pend_v & ((r_active == 32'd0) | w_carry);
    assign w_tick   = (r_div == DIV_LAST);
    assign w_p      = r_phase[31:24];

    always_comb begin
        w_wave = 8'd0;
        case (wave_e'(wave_sel_i))
            WAVE_SQUARE: w_wave = w_p[7] ? 8'hFF : 8'h00;
            WAVE_SAW:    w_wave = w_p;
            WAVE_TRI:    w_wave = w_p[7] ? ~{w_p[6:0], 1'b0} : {w_p[6:0], 1'b0};
            WAVE_OFF:    w_wave = 8'd0;
            default:     w_wave = 8'd0;
        endcase
    end

    assign w_scaled = 8'(({8'd0, w_wave} * {8'd0, r_env}) >> 8);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_phase   <= 32'd0;
            r_active  <= 32'd0;
            r_pending <= 32'd0;
            r_pend_v  <= 1'b0;
            r_wrap    <= 1'b0;
        end else begin
            r_phase <= w_sum[31:0];
            r_wrap  <= w_carry;
            if (w_apply) begin
                r_active <= r_pending;
                r_pend_v <= 1'b0;
            end else if (w_accept) begin
                r_pending <= fstep_i;
                r_pend_v  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_div <= '0;
            r_env <= 8'd0;
        end else begin
            r_div <= w_tick ? '0 : r_div + DIV_W'(1);
            if (w_tick) begin
                if (gate_i && (r_env != 8'hFF))
                    r_env <= r_env + 8'd1;
                else if (!gate_i && (r_env != 8'h00))
                    r_env <= r_env - 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_sample  <= 8'd0;
            r_pwm     <= 1'b0;
            r_pwm_cnt <= 8'd0;
        end else begin
            r_sample  <= w_scaled;
            r_pwm     <= (r_pwm_cnt < r_sample);
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
        end
    end

    assign fstep_ready_o = ~r_pend_v;
    assign sample_o      = r_sample;
    assign pwm_o         = r_pwm;
    assign wrap_o        = r_wrap;
endmodule
